ats21_cmd_tx: RTL and testbench

- Host-side command initiator for the ATS21 alarm/timer block.
- Accepts paired 32-bit commands (channel A and channel B) into a small FIFO.
- Serialises each pair onto the 16-bit ctrlA/ctrlB bus as two req/ready beats: upper half [31:16] first, then lower half [15:0].
- Sits between the test/host sequencer and the ATS21 command port. Its req/ctrlA/ctrlB/ready pins connect directly to the ATS21 pins of the same name.

---
 rtl/ats21_pkg.sv | 39 +++
 rtl/ats21_cmd_fifo.sv | 56 +++++
 rtl/ats21_cmd_tx.sv | 154 +++++++++++++++
 tb/tb_ats21_cmd_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command initiator.
// Holds the command opcodes, transmitter states, the bus widths and the
// {a, b} command-pair payload.
package ats21_pkg;

  localparam int unsigned CMD_W  = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    NOP       = 3'b000,
    SET_CLK   = 3'b001,
    CLK_EN    = 3'b010,
    SET_MODE  = 3'b011,
    SET_ALARM = 3'b101,
    SET_TIMER = 3'b110,
    AT_EN     = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO
  } tx_state_t;

  typedef struct packed {
    logic [CMD_W-1:0] a;
    logic [CMD_W-1:0] b;
  } cmd_pair_t;

  // Upper and lower half-words of a command word.
  function automatic logic [HALF_W-1:0] hi_half(input logic [CMD_W-1:0] w);
    return w[CMD_W-1:HALF_W];
  endfunction

  function automatic logic [HALF_W-1:0] lo_half(input logic [CMD_W-1:0] w);
    return w[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Synchronous FIFO of command pairs.
// Ports: clk, reset (sync, active-low), push/push_data, pop,
//        full_c/empty_c (decoded occupancy), count (registered occupancy),
//        head_c (oldest entry), second_c (entry behind the head).
module ats21_cmd_fifo
  import ats21_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_pair_t              push_data,
  input  logic                   pop,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count,
  output cmd_pair_t              head_c,
  output cmd_pair_t              second_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_pair_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c   = (count == CNT_W'(DEPTH));
  assign empty_c  = (count == '0);
  assign do_push  = push && !full_c;
  assign do_pop   = pop && !empty_c;
  assign head_c   = mem[rd_ptr];
  assign second_c = mem[rd_ptr + PTR_W'(1)];

  // Storage; no reset needed, occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo DEPTH; the extra count bit separates full from empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ats21_cmd_tx.sv
// Host-side ATS21 command initiator: queues {cmd_a, cmd_b} pairs and sends
// each as two req/ready beats (upper half-words, then lower half-words).
// Ports: clk, reset (sync, active-low); host side cmd_valid/cmd_ready/cmd_a/
//        cmd_b; ATS21 side req/ctrlA/ctrlB/ready; status busy, level,
//        done (pair sent pulse), err (pair aborted by timeout pulse).
module ats21_cmd_tx
  import ats21_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CMD_W-1:0]       cmd_a,
  input  logic [CMD_W-1:0]       cmd_b,
  output logic                   req,
  output logic [HALF_W-1:0]      ctrlA,
  output logic [HALF_W-1:0]      ctrlB,
  input  logic                   ready,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic [15:0]        stall;
  logic [15:0]        stall_nxt;
  logic               push;
  logic               pop;
  logic               done_nxt;
  logic               err_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [HALF_W-1:0]  ctrl_a_nxt;
  logic [HALF_W-1:0]  ctrl_b_nxt;
  cmd_pair_t          push_data;
  cmd_pair_t          head_nxt;
  cmd_pair_t          head_c;
  cmd_pair_t          second_c;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  assign push_data.a = cmd_a;
  assign push_data.b = cmd_b;
  assign push        = cmd_valid && cmd_ready && !fifo_full;
  assign level       = fifo_count;
  assign cnt_nxt     = fifo_count + CNT_W'(push) - CNT_W'(pop);

  ats21_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count     (fifo_count),
    .head_c    (head_c),
    .second_c  (second_c)
  );

  // Next state, stall counting, pop and pulse generation.
  always_comb begin
    state_nxt = state;
    stall_nxt = stall;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_nxt = SEND_HI;
      end
      SEND_HI, SEND_LO: begin
        if (ready) begin
          stall_nxt = '0;
          if (state == SEND_HI) begin
            state_nxt = SEND_LO;
          end else begin
            pop       = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = ((fifo_count > CNT_W'(1)) || push) ? SEND_HI : IDLE;
          end
        end else if (stall == TIMEOUT_M1) begin
          // Abort: drop the pair, no retry, force one idle cycle.
          pop       = 1'b1;
          err_nxt   = 1'b1;
          stall_nxt = '0;
          state_nxt = IDLE;
        end else begin
          stall_nxt = stall + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Half-words for the next cycle. After a pop the new head is either the
  // entry behind it or, when the queue held one pair, the word pushed now.
  always_comb begin
    head_nxt   = head_c;
    ctrl_a_nxt = '0;
    ctrl_b_nxt = '0;
    if (pop) head_nxt = (fifo_count > CNT_W'(1)) ? second_c : push_data;
    case (state_nxt)
      SEND_HI: begin
        ctrl_a_nxt = hi_half(head_nxt.a);
        ctrl_b_nxt = hi_half(head_nxt.b);
      end
      SEND_LO: begin
        ctrl_a_nxt = lo_half(head_c.a);
        ctrl_b_nxt = lo_half(head_c.b);
      end
      default: begin
        ctrl_a_nxt = '0;
        ctrl_b_nxt = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      stall     <= '0;
      req       <= 1'b0;
      ctrlA     <= '0;
      ctrlB     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall     <= stall_nxt;
      req       <= (state_nxt != IDLE);
      ctrlA     <= ctrl_a_nxt;
      ctrlB     <= ctrl_b_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      busy      <= (state_nxt != IDLE) || (cnt_nxt != '0);
      cmd_ready <= (cnt_nxt != CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_ats21_cmd_tx.sv
// Bench for ats21_cmd_tx: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ats21_cmd_tx;
  import ats21_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        req;
  logic [15:0] ctrlA;
  logic [15:0] ctrlB;
  logic        ready;
  logic        busy;
  logic [2:0]  level;
  logic        done;
  logic        err;

  ats21_cmd_tx #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .req(req), .ctrlA(ctrlA), .ctrlB(ctrlB),
    .ready(ready), .busy(busy), .level(level), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: queued pairs, whether a pair is on the bus,
  // which half is on the bus, consecutive stalls, expected pulses.
  cmd_pair_t q[$];
  bit        m_ok   = 1'b0;
  bit        m_act  = 1'b0;
  bit        m_half = 1'b0;
  bit        m_rdy  = 1'b0;
  bit        m_done = 1'b0;
  bit        m_err  = 1'b0;
  int        m_stall = 0;

  logic [31:0] beat_log [64];
  int          done_cyc [32];
  int          beat_n = 0;
  int          done_n = 0;
  int          err_n  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare outputs with the model, then advance the model over the next edge.
  task automatic monitor();
    logic [15:0] ea, eb;
    logic        pu;
    cmd_pair_t   np;
    if (m_ok) begin
      ea = '0;
      eb = '0;
      if (m_act && q.size() != 0) begin
        ea = m_half ? q[0].a[15:0] : q[0].a[31:16];
        eb = m_half ? q[0].b[15:0] : q[0].b[31:16];
      end
      chk("req", 32'(req), 32'(m_act));
      chk("ctrlA", 32'(ctrlA), 32'(ea));
      chk("ctrlB", 32'(ctrlB), 32'(eb));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("level", 32'(level), 32'(q.size()));
      chk("busy", 32'(busy), 32'(m_act || q.size() != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_rdy));
      if (done === 1'b1 && done_n < 32) begin done_cyc[done_n] = cyc; done_n++; end
      if (err === 1'b1) err_n++;
    end
    if (reset === 1'b0) begin
      q.delete();
      m_act = 0; m_half = 0; m_stall = 0; m_done = 0; m_err = 0; m_rdy = 0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      pu = cmd_valid && m_rdy;
      np.a = cmd_a;
      np.b = cmd_b;
      m_done = 0;
      m_err  = 0;
      if (m_act) begin
        if (ready) begin
          if (beat_n < 64) begin beat_log[beat_n] = {ctrlA, ctrlB}; beat_n++; end
          m_stall = 0;
          if (!m_half) m_half = 1;
          else begin
            void'(q.pop_front());
            m_done = 1;
            m_half = 0;
            m_act  = (q.size() + int'(pu)) > 0;
          end
        end else begin
          m_stall++;
          if (m_stall == TIMEOUT) begin
            void'(q.pop_front());
            m_err = 1; m_act = 0; m_half = 0; m_stall = 0;
          end
        end
      end else if (q.size() != 0) begin
        m_act  = 1;
        m_half = 0;
      end
      if (pu) q.push_back(np);
      m_rdy = (q.size() != DEPTH);
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cmd_ready();
    for (int k = 0; k < 10 && cmd_ready !== 1'b1; k++) step();
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bb, db, eb;
    reset = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; ready = 1'b0;
    repeat (3) step();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrlA", 32'(ctrlA), 32'd0);
    reset = 1'b1;
    wait_cmd_ready();

    // Single pair, ready held high.
    ready = 1'b1; bb = beat_n; db = done_n;
    push_pair(32'h2A80_0000, 32'h0); n = cyc;
    step();
    chk("t1_req_rise", 32'(req), 32'd1);
    chk("t1_ctrlA_hi", 32'(ctrlA), 32'h2A80);
    repeat (4) step();
    chk("t1_beats", 32'(beat_n - bb), 32'd2);
    chk("t1_beat0", beat_log[bb], 32'h2A80_0000);
    chk("t1_beat1", beat_log[bb+1], 32'h0000_0000);
    chk("t1_dones", 32'(done_n - db), 32'd1);
    chk("t1_done_lat", 32'(done_cyc[db] - n), 32'd3);
    chk("t1_level", 32'(level), 32'd0);

    // Fill to full with ready low, then drain back-to-back.
    ready = 1'b0; bb = beat_n; db = done_n;
    for (int i = 0; i < 4; i++)
      push_pair({16'(16'hA100 + i), 16'(16'hA200 + i)}, {16'(16'hB100 + i), 16'(16'hB200 + i)});
    chk("t2_full_ready", 32'(cmd_ready), 32'd0);
    chk("t2_full_level", 32'(level), 32'd4);
    push_pair(32'hDEAD_BEEF, 32'hCAFE_F00D);
    chk("t2_5th_rejected", 32'(level), 32'd4);
    ready = 1'b1;
    repeat (10) step();
    chk("t2_beats", 32'(beat_n - bb), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("t2_beat_hi", beat_log[bb+2*i],   {16'(16'hA100 + i), 16'(16'hB100 + i)});
      chk("t2_beat_lo", beat_log[bb+2*i+1], {16'(16'hA200 + i), 16'(16'hB200 + i)});
    end
    chk("t2_dones", 32'(done_n - db), 32'd4);
    for (int i = 0; i < 3; i++)
      chk("t2_done_gap", 32'(done_cyc[db+i+1] - done_cyc[db+i]), 32'd2);

    // Ready pattern 1,0,0,1 across one pair.
    ready = 1'b0; bb = beat_n; db = done_n;
    push_pair(32'h5123_4567, 32'h6789_ABCD); n = cyc;
    step();
    ready = 1'b1; step();
    ready = 1'b0; step(); step();
    ready = 1'b1; step();
    repeat (3) step();
    chk("t3_beats", 32'(beat_n - bb), 32'd2);
    chk("t3_beat_hi", beat_log[bb], 32'h5123_6789);
    chk("t3_beat_lo", beat_log[bb+1], 32'h4567_ABCD);
    chk("t3_dones", 32'(done_n - db), 32'd1);
    chk("t3_done_cyc", 32'(done_cyc[db] - n), 32'd5);

    // Timeout in SEND_HI, then the next pair restarts.
    ready = 1'b0; bb = beat_n; db = done_n; eb = err_n;
    push_pair(32'hC001_C002, 32'hC003_C004); n = cyc;
    push_pair(32'hD001_D002, 32'hD003_D004);
    repeat (8) step();
    chk("t4_err_cyc", 32'(cyc - n), 32'd9);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_req_drop", 32'(req), 32'd0);
    step();
    chk("t4_restart_req", 32'(req), 32'd1);
    chk("t4_restart_a", 32'(ctrlA), 32'hD001);
    ready = 1'b1;
    repeat (4) step();
    chk("t4_errs", 32'(err_n - eb), 32'd1);
    chk("t4_beats", 32'(beat_n - bb), 32'd2);
    chk("t4_beat_hi", beat_log[bb], 32'hD001_D003);
    chk("t4_dones", 32'(done_n - db), 32'd1);

    // Push and pop on the same edge at level 2.
    ready = 1'b0; bb = beat_n; db = done_n;
    push_pair(32'h1111_AAAA, 32'h0101_0A0A);
    push_pair(32'h2222_BBBB, 32'h0202_0B0B);
    ready = 1'b1; step();
    push_pair(32'h3333_CCCC, 32'h0303_0C0C);
    chk("t5_level_same", 32'(level), 32'd2);
    repeat (6) step();
    chk("t5_beats", 32'(beat_n - bb), 32'd6);
    chk("t5_b0", beat_log[bb],   32'h1111_0101);
    chk("t5_b1", beat_log[bb+1], 32'hAAAA_0A0A);
    chk("t5_b2", beat_log[bb+2], 32'h2222_0202);
    chk("t5_b3", beat_log[bb+3], 32'hBBBB_0B0B);
    chk("t5_b4", beat_log[bb+4], 32'h3333_0303);
    chk("t5_b5", beat_log[bb+5], 32'hCCCC_0C0C);
    chk("t5_dones", 32'(done_n - db), 32'd3);

    // Reset during SEND_LO with three pairs queued.
    ready = 1'b0;
    push_pair(32'h7001_7002, 32'h7003_7004);
    push_pair(32'h7101_7102, 32'h7103_7104);
    push_pair(32'h7201_7202, 32'h7203_7204);
    ready = 1'b1; step();
    chk("t6_in_lo", 32'(ctrlA), 32'h7002);
    ready = 1'b0; reset = 1'b0; db = done_n; eb = err_n;
    step();
    chk("t6_req", 32'(req), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_ctrlA", 32'(ctrlA), 32'd0);
    reset = 1'b1;
    wait_cmd_ready();
    bb = beat_n;
    ready = 1'b1;
    push_pair(32'h4E01_4E02, 32'h4E03_4E04);
    repeat (5) step();
    chk("t6_beats", 32'(beat_n - bb), 32'd2);
    chk("t6_beat_hi", beat_log[bb], 32'h4E01_4E03);
    chk("t6_beat_lo", beat_log[bb+1], 32'h4E02_4E04);
    chk("t6_dones", 32'(done_n - db), 32'd1);
    chk("t6_no_err", 32'(err_n - eb), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
